pixel_stream_tx: RTL

//  Video source for the detection pipeline: reads an RGB frame from a frame-buffer read port, or generates a test pattern.

---
 rtl/pixel_stream_tx_pkg.sv | 29 ++
 rtl/pixel_stream_tx_timing_gen.sv | 88 ++++++++
 rtl/pixel_stream_tx.sv | 128 ++++++++++++
 3 files changed

// File: rtl/pixel_stream_tx_pkg.sv
// pixel_stream_tx_pkg: shared pixel width, pattern codes and generator state encoding.
// rev 1.0
`default_nettype none

package pixel_stream_tx_pkg;

  localparam int PIXEL_SIZE = 24;

  localparam logic [1:0] PAT_MEM   = 2'd0;
  localparam logic [1:0] PAT_SOLID = 2'd1;
  localparam logic [1:0] PAT_RAMP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_VBLANK = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_HBLANK = 2'd3
  } tx_state_e;

  // Pixels are packed {B,G,R} with R in the low byte.
  function automatic logic [PIXEL_SIZE-1:0] pack_bgr(input logic [7:0] b,
                                                     input logic [7:0] g,
                                                     input logic [7:0] r);
    return {b, g, r};
  endfunction

endpackage

`default_nettype wire

// File: rtl/pixel_stream_tx_timing_gen.sv
// tx_timing_gen: raster FSM with column/row/address counters and blanking timers.
// rev 1.0
`default_nettype none

module tx_timing_gen
  import pixel_stream_tx_pkg::*;
#(
  parameter int FRAME_WIDTH  = 550,
  parameter int FRAME_HEIGHT = 4,
  parameter int H_BLANK      = 4,
  parameter int V_BLANK      = 8,
  parameter int ADDR_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  stop,
  input  logic                  hold,
  output logic                  active,
  output logic                  hs,
  output logic                  vs,
  output logic                  last,
  output logic                  running,
  output logic [15:0]           col,
  output logic [15:0]           row,
  output logic [ADDR_WIDTH-1:0] addr
);

  tx_state_e   state, state_nx;
  logic [15:0] cnt;
  logic        loop_latch;
  logic        row_end;
  logic        last_row;
  logic        accept;

  assign row_end  = (col == 16'(FRAME_WIDTH - 1));
  assign last_row = (row == 16'(FRAME_HEIGHT - 1));
  // A fresh start is refused while the previous frame still drains the pipeline.
  assign accept   = (state == ST_IDLE) && start && !hold && !loop_latch;

  assign active  = (state == ST_ACTIVE);
  assign vs      = (state == ST_VBLANK) && (cnt == 16'(V_BLANK - 1));
  assign hs      = (state == ST_HBLANK) && (cnt == 16'(H_BLANK - 1));
  assign last    = active && row_end && last_row;
  assign running = (state != ST_IDLE);

  // Looping frames re-enter through one IDLE cycle, so every frame has the same period.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (loop_latch || accept) state_nx = ST_VBLANK;
      ST_VBLANK: if (cnt == 16'(V_BLANK - 1)) state_nx = ST_ACTIVE;
      ST_ACTIVE: if (row_end) state_nx = last_row ? ST_IDLE : ST_HBLANK;
      ST_HBLANK: if (cnt == 16'(H_BLANK - 1)) state_nx = ST_ACTIVE;
      default:   state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      col        <= '0;
      row        <= '0;
      addr       <= '0;
      loop_latch <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= (state_nx != state) ? '0 : cnt + 16'd1;

      if (stop)        loop_latch <= 1'b0;
      else if (accept) loop_latch <= continuous;

      if (active) col <= row_end ? '0 : col + 16'd1;
      else        col <= '0;

      if (state == ST_VBLANK)      row <= '0;
      else if (active && row_end)  row <= row + 16'd1;

      if (state == ST_VBLANK) addr <= '0;
      else if (active)        addr <= addr + ADDR_WIDTH'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/pixel_stream_tx.sv
// pixel_stream_tx: frame-buffer / test-pattern raster source with hsync/vsync framing.
// rev 1.0
`default_nettype none

module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int FRAME_WIDTH  = 550,
  parameter int FRAME_HEIGHT = 4,
  parameter int H_BLANK      = 4,
  parameter int V_BLANK      = 8,
  parameter int ADDR_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic                  continuous,
  input  logic                  stop,
  input  logic [1:0]            pattern_sel,
  input  logic [PIXEL_SIZE-1:0] pattern_rgb,
  output logic                  mem_rd_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [PIXEL_SIZE-1:0] mem_rdata,
  output logic                  en,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIXEL_SIZE-1:0] data,
  output logic                  frame_done,
  output logic                  busy,
  output logic [15:0]           frame_count
);

  logic                  g_active, g_hs, g_vs, g_last, running;
  logic [15:0]           col, row;
  logic [ADDR_WIDTH-1:0] gen_addr;
  logic [1:0]            pat;
  logic [PIXEL_SIZE-1:0] gen_pix;
  logic                  s1_en, s1_hs, s1_vs, s1_last, s1_mem;
  logic [PIXEL_SIZE-1:0] s1_pix;
  logic                  done_q;
  logic                  hold;
  logic                  unused_bits;

  assign hold        = s1_last | frame_done | done_q;
  assign busy        = running | hold;
  assign mem_rd_en   = g_active && (pat == PAT_MEM);
  assign mem_addr    = mem_rd_en ? gen_addr : '0;
  assign unused_bits = ^{col[15:8], row[15:8]};

  tx_timing_gen #(
    .FRAME_WIDTH  (FRAME_WIDTH),
    .FRAME_HEIGHT (FRAME_HEIGHT),
    .H_BLANK      (H_BLANK),
    .V_BLANK      (V_BLANK),
    .ADDR_WIDTH   (ADDR_WIDTH)
  ) u_timing (
    .clk        (clk),
    .reset_n    (reset_n),
    .start      (start),
    .continuous (continuous),
    .stop       (stop),
    .hold       (hold),
    .active     (g_active),
    .hs         (g_hs),
    .vs         (g_vs),
    .last       (g_last),
    .running    (running),
    .col        (col),
    .row        (row),
    .addr       (gen_addr)
  );

  always_comb begin
    gen_pix = pattern_rgb;
    case (pat)
      PAT_RAMP:  gen_pix = pack_bgr(frame_count[7:0], row[7:0], col[7:0]);
      PAT_SOLID: gen_pix = pattern_rgb;
      default:   gen_pix = pattern_rgb;
    endcase
  end

  // Pattern is captured on the vsync cycle so it stays fixed for the whole frame.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pat     <= PAT_MEM;
      s1_en   <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_last <= 1'b0;
      s1_mem  <= 1'b0;
      s1_pix  <= '0;
    end else begin
      if (g_vs) pat <= pattern_sel;
      s1_en   <= g_active;
      s1_hs   <= g_hs;
      s1_vs   <= g_vs;
      s1_last <= g_last;
      s1_mem  <= (pat == PAT_MEM);
      s1_pix  <= gen_pix;
    end
  end

  // Second stage lines up with the frame-buffer read data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      en          <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      data        <= '0;
      frame_done  <= 1'b0;
      done_q      <= 1'b0;
      frame_count <= '0;
    end else begin
      en         <= s1_en;
      hsync      <= s1_hs;
      vsync      <= s1_vs;
      frame_done <= s1_last;
      done_q     <= frame_done;
      if (!s1_en)      data <= '0;
      else if (s1_mem) data <= mem_rdata;
      else             data <= s1_pix;
      if (s1_last) frame_count <= frame_count + 16'd1;
    end
  end

endmodule

`default_nettype wire
